// File: rtl/block_loader.sv
// ============================================================================
// Module   : block_loader
// Purpose  : Gathers 32-bit key/plaintext words into 128-bit blocks, starts the
//            encryptor, captures its result and streams it back out as words.
//            Optional macro KEY_REUSE_EN keeps the previous key when key_hold=1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module block_loader (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  in_word,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         key_hold,
  output logic [127:0] enc_key,
  output logic [127:0] enc_plaintext,
  output logic         enc_start,
  input  logic         enc_done,
  input  logic [127:0] enc_ciphertext,
  output logic [31:0]  out_word,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_LOAD_KEY = 3'd0,
    S_LOAD_PT  = 3'd1,
    S_START    = 3'd2,
    S_WAIT     = 3'd3,
    S_DRAIN    = 3'd4
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   widx_q, widx_d;
  logic [127:0] key_q, key_d;
  logic [127:0] pt_q, pt_d;
  logic [127:0] ct_q, ct_d;

  logic [6:0]   w_msb;
  logic         w_in_xfer;
  logic         w_out_xfer;

  // Word 0 lands in the most-significant lane.
  assign w_msb      = 7'd127 - {widx_q, 5'd0};
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  assign in_ready      = ~rst & ((state_q == S_LOAD_KEY) | (state_q == S_LOAD_PT));
  assign enc_start     = (state_q == S_START);
  assign out_valid     = (state_q == S_DRAIN);
  assign out_word      = out_valid ? ct_q[w_msb -: 32] : 32'd0;
  assign busy          = ~((state_q == S_LOAD_KEY) && (widx_q == 2'd0));
  assign enc_key       = key_q;
  assign enc_plaintext = pt_q;

`ifndef KEY_REUSE_EN
  logic w_unused;
  assign w_unused = key_hold;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD_KEY;
      widx_q  <= 2'd0;
      key_q   <= '0;
      pt_q    <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
      ct_q    <= ct_d;
    end
  end

  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    key_d   = key_q;
    pt_d    = pt_q;
    ct_d    = ct_q;
    case (state_q)
      S_LOAD_KEY: begin
        if (w_in_xfer) begin
          key_d[w_msb -: 32] = in_word;
          widx_d             = widx_q + 2'd1;
          if (widx_q == 2'd3) state_d = S_LOAD_PT;
        end
      end
      S_LOAD_PT: begin
        if (w_in_xfer) begin
          pt_d[w_msb -: 32] = in_word;
          widx_d            = widx_q + 2'd1;
          if (widx_q == 2'd3) state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (enc_done) begin
          ct_d    = enc_ciphertext;
          widx_d  = 2'd0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_out_xfer) begin
          widx_d = widx_q + 2'd1;
          if (widx_q == 2'd3) begin
            widx_d = 2'd0;
`ifdef KEY_REUSE_EN
            state_d = key_hold ? S_LOAD_PT : S_LOAD_KEY;
`else
            state_d = S_LOAD_KEY;
`endif
          end
        end
      end
      default: begin
        state_d = S_LOAD_KEY;
        widx_d  = 2'd0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_block_loader.sv
// ============================================================================
// Module   : tb_block_loader
// Purpose  : Self-checking bench for block_loader with an encryptor stub and an
//            output-word scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_block_loader;

  logic         clk;
  logic         rst;
  logic [31:0]  in_word;
  logic         in_valid;
  logic         in_ready;
  logic         key_hold;
  logic [127:0] enc_key;
  logic [127:0] enc_plaintext;
  logic         enc_start;
  logic         enc_done;
  logic [127:0] enc_ciphertext;
  logic [31:0]  out_word;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  block_loader dut (
    .clk            (clk),
    .rst            (rst),
    .in_word        (in_word),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .key_hold       (key_hold),
    .enc_key        (enc_key),
    .enc_plaintext  (enc_plaintext),
    .enc_start      (enc_start),
    .enc_done       (enc_done),
    .enc_ciphertext (enc_ciphertext),
    .out_word       (out_word),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           checks;
  int           failures;
  int           cyc_cnt;
  int           starts;
  int           start_cyc;
  int           first_xfer_cyc;
  int           stub_cnt;
  bit           in_xfer;
  bit           hold_chk;
  bit           spur;
  logic [127:0] ct_stub;
  logic [127:0] exp_key;
  logic [127:0] exp_pt;
  logic [127:0] key_at_start;
  logic [31:0]  exp_q[$];

  // One clock: judge handshakes for the coming edge, then sample the new cycle
  // and drive the encryptor stub (done exactly 3 cycles after enc_start).
  task automatic step();
    logic [31:0] e;
    #1;
    in_xfer = in_valid && in_ready;
    if (in_xfer && first_xfer_cyc < 0) first_xfer_cyc = cyc_cnt;
    if (out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_extra: out_word=%h taken with nothing expected", out_word);
      end else begin
        e = exp_q.pop_front();
        if (out_word !== e) begin
          failures++;
          $display("FAIL out_word: got %h expected %h", out_word, e);
        end
      end
    end
    @(negedge clk);
    #1;
    cyc_cnt++;
    if (enc_start === 1'b1) begin
      starts++;
      start_cyc    = cyc_cnt;
      key_at_start = enc_key;
      hold_chk     = 1'b1;
      stub_cnt     = 4;
    end else if (stub_cnt > 0) begin
      stub_cnt--;
    end
    if (hold_chk) begin
      if (out_valid) hold_chk = 1'b0;
      else begin
        checks++;
        if (enc_key !== exp_key || enc_plaintext !== exp_pt) begin
          failures++;
          $display("FAIL key_pt_hold: key=%h pt=%h expected key=%h pt=%h",
                   enc_key, enc_plaintext, exp_key, exp_pt);
        end
      end
    end
    enc_done       = (stub_cnt == 1) || spur;
    enc_ciphertext = (stub_cnt == 1) ? ct_stub : ~ct_stub;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic put_word(input logic [31:0] w);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_word  = w;
    do begin
      step();
      n++;
    end while (!in_xfer && n < 50);
    in_valid = 1'b0;
    checks++;
    if (!in_xfer) begin
      failures++;
      $display("FAIL put_word: word %h not accepted after %0d cycles, required accepted", w, n);
    end
  endtask

  task automatic send4(input logic [127:0] d, input bit gap);
    for (int i = 0; i < 4; i++) begin
      put_word(d[127 - 32*i -: 32]);
      if (gap) idle(1);
    end
  endtask

  task automatic expect_block(input logic [127:0] k, input logic [127:0] p, input logic [127:0] c);
    exp_key        = k;
    exp_pt         = p;
    ct_stub        = c;
    first_xfer_cyc = -1;
    for (int i = 0; i < 4; i++) exp_q.push_back(c[127 - 32*i -: 32]);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d words still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_word  = 32'hFFFF_FFFF;
    idle(2);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || enc_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl: in_ready=%b busy=%b out_valid=%b enc_start=%b required 0 0 0 0",
               in_ready, busy, out_valid, enc_start);
    end
    checks++;
    if (enc_key !== 128'd0 || enc_plaintext !== 128'd0 || out_word !== 32'd0) begin
      failures++;
      $display("FAIL reset_data: key=%h pt=%h out_word=%h required zeros", enc_key, enc_plaintext, out_word);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int s0;
    s0 = starts;
    expect_block(128'd25, 128'd1407, {4{32'hA5A5_A5A5}});
    send4(128'd25, 1'b0);
    send4(128'd1407, 1'b0);
    wait_done("basic");
    checks++;
    if (starts - s0 != 1) begin
      failures++;
      $display("FAIL basic_starts: got %0d pulses required 1", starts - s0);
    end
    checks++;
    if (start_cyc - first_xfer_cyc != 8) begin
      failures++;
      $display("FAIL basic_latency: got %0d cycles required 8", start_cyc - first_xfer_cyc);
    end
    checks++;
    if (key_at_start !== 128'd25) begin
      failures++;
      $display("FAIL basic_key: got %h required %h", key_at_start, 128'd25);
    end
  endtask

  task automatic test_bubbles();
    expect_block(128'd25, 128'd1407, {4{32'hA5A5_A5A5}});
    send4(128'd25, 1'b1);
    for (int i = 0; i < 4; i++) begin
      put_word(128'd1407 >> (96 - 32*i));
      if (i < 3) idle(1);
    end
    wait_done("bubbles");
    checks++;
    if (start_cyc - first_xfer_cyc != 15) begin
      failures++;
      $display("FAIL bubbles_latency: got %0d cycles required 15", start_cyc - first_xfer_cyc);
    end
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    expect_block(128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10, 128'hCAFE,
                 128'h1111_1111_2222_2222_3333_3333_4444_4444);
    send4(128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10, 1'b0);
    send4(128'hCAFE, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_word !== 32'h1111_1111 || busy !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold: out_valid=%b out_word=%h busy=%b required 1 11111111 1",
                 out_valid, out_word, busy);
      end
      step();
    end
    out_ready = 1'b1;
    wait_done("backpressure");
  endtask

  task automatic test_spurious_done();
    expect_block(128'h77, 128'h99, 128'hDEAD_BEEF_0BAD_F00D_1234_5678_9ABC_DEF0);
    send4(128'h77, 1'b0);
    spur = 1'b1;
    send4(128'h99, 1'b0);
    checks++;
    if (enc_start !== 1'b1) begin
      failures++;
      $display("FAIL spur_start: enc_start=%b required 1", enc_start);
    end
    spur = 1'b0;
    wait_done("spurious");
  endtask

  task automatic test_reset_mid();
    int s0;
    send4(128'h11, 1'b0);
    put_word(32'h0);
    put_word(32'h5);
    s0  = starts;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || enc_key !== 128'd0 || enc_plaintext !== 128'd0) begin
      failures++;
      $display("FAIL rstmid_state: in_ready=%b busy=%b key=%h pt=%h required 1 0 0 0",
               in_ready, busy, enc_key, enc_plaintext);
    end
    idle(6);
    checks++;
    if (starts != s0) begin
      failures++;
      $display("FAIL rstmid_nostart: got %0d pulses required 0", starts - s0);
    end
    expect_block(128'd1293, 128'd285, 128'h0F0F_0F0F_F0F0_F0F0_5555_5555_AAAA_AAAA);
    send4(128'd1293, 1'b0);
    send4(128'd285, 1'b0);
    wait_done("rstmid");
    checks++;
    if (key_at_start !== 128'd1293) begin
      failures++;
      $display("FAIL rstmid_key: got %h required %h", key_at_start, 128'd1293);
    end
  endtask

  task automatic test_key_hold();
    key_hold = 1'b1;
    expect_block(128'd25, 128'd1407, {4{32'hA5A5_A5A5}});
    send4(128'd25, 1'b0);
    send4(128'd1407, 1'b0);
    wait_done("hold1");
    key_hold = 1'b0;
`ifdef KEY_REUSE_EN
    expect_block(128'd25, 128'h1234, 128'h8765_4321_0FED_CBA9_1357_9BDF_2468_ACE0);
    send4(128'h1234, 1'b0);
    wait_done("hold2");
    checks++;
    if (key_at_start !== 128'd25 || start_cyc - first_xfer_cyc != 4) begin
      failures++;
      $display("FAIL key_reuse: key=%h latency=%0d required key=%h latency=4",
               key_at_start, start_cyc - first_xfer_cyc, 128'd25);
    end
`else
    expect_block(128'h77, 128'h1234, 128'h8765_4321_0FED_CBA9_1357_9BDF_2468_ACE0);
    send4(128'h77, 1'b0);
    send4(128'h1234, 1'b0);
    wait_done("hold2");
    checks++;
    if (key_at_start !== 128'h77 || start_cyc - first_xfer_cyc != 8) begin
      failures++;
      $display("FAIL key_hold_ignored: key=%h latency=%0d required key=%h latency=8",
               key_at_start, start_cyc - first_xfer_cyc, 128'h77);
    end
`endif
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    cyc_cnt        = 0;
    starts         = 0;
    start_cyc      = 0;
    first_xfer_cyc = -1;
    stub_cnt       = 0;
    in_xfer        = 1'b0;
    hold_chk       = 1'b0;
    spur           = 1'b0;
    ct_stub        = '0;
    exp_key        = '0;
    exp_pt         = '0;
    key_at_start   = '0;
    rst            = 1'b1;
    in_word        = '0;
    in_valid       = 1'b0;
    key_hold       = 1'b0;
    enc_done       = 1'b0;
    enc_ciphertext = '0;
    out_ready      = 1'b1;

    test_reset();
    test_basic();
    test_bubbles();
    test_backpressure();
    test_spurious_done();
    test_reset_mid();
    test_key_hold();
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
